multi_bit_bpred_table: RTL and testbench
========================================

Name: multi_bit_bpred_table

Overview:
- Parametrised table of N-bit saturating branch-direction counters, indexed by low PC bits. Successor to the single 2-bit predictor FSM.
- Adds configurable depth and counter width, selectable saturating or hysteresis update mode, and a registered lookup port with a separate update port.
- Sits in fetch: lookup at fetch, update at branch resolution.

Parameters:
- CTR_BITS, 2, counter width (>=2).
- INDEX_BITS, 4, table index width; entries = 2**INDEX_BITS.
- MODE, 0, update rule: 0 = plain saturating, 1 = hysteresis (weak state jumps to strong on mispredict).
- HIST_BITS, 4, global history length (1..INDEX_BITS); used only with BPRED_GSHARE_EN.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous reinitialise of all counters and history
- lookup_valid  in  1  lookup request this cycle
- lookup_idx  in  INDEX_BITS  PC bits for lookup
- pred_valid  out  1  registered; lookup result valid
- prediction  out  1  registered; 1 = taken (counter MSB)
- pred_strong  out  1  registered; counter at 0 or max
- pred_index  out  INDEX_BITS  registered; table index actually read, returned by caller on update
- update_valid  in  1  resolve a branch this cycle
- update_idx  in  INDEX_BITS  table index to update (the pred_index of that branch)
- update_taken  in  1  resolved direction

Behaviour:
- Counter init value INIT = 2**(CTR_BITS-1)-1 (weakly not-taken; 2'b01 for CTR_BITS=2).
- Reset (reset=0, async): all counters = INIT; history = 0; pred_valid = 0, prediction = 0, pred_strong = 0, pred_index = 0.
- Lookup latency is 1 cycle. When lookup_valid is high at edge k:
  - At k+1: pred_valid = 1; pred_index = hashed index; prediction = MSB of the counter; pred_strong = (ctr==0 || ctr==max).
  - When lookup_valid is low, pred_valid = 0 next cycle; the other outputs hold their values.
- Update applies at the edge where update_valid = 1, to entry update_idx:
  - MODE 0: taken -> ctr+1, saturating at max; not-taken -> ctr-1, saturating at 0.
  - MODE 1: weak states are WNT = 2**(CTR_BITS-1)-1 and WT = 2**(CTR_BITS-1).
    - WNT & taken -> max.
    - WT & not-taken -> 0.
    - All other cases: saturating ±1 as in MODE 0.
    - For CTR_BITS=2 this gives 00 -T-> 01, 01 -T-> 11, 01 -N-> 00, 10 -T-> 11, 10 -N-> 00, 11 -N-> 10.
- Same cycle, same index, lookup and update: lookup returns the pre-update counter (read-before-write). The update is still applied.
- flush = 1 at an edge: all counters = INIT, history = 0. flush wins over a coincident update. A coincident lookup still returns the pre-flush value. pred_* outputs are not cleared by flush.
- Indices use plain truncation. No wrap or overflow is possible beyond saturation.
- Reset asserted mid-operation clears everything immediately and asynchronously. The first lookup after deassertion sees INIT.

Optional Feature:
- Macro BPRED_GSHARE_EN.
- Defined:
  - HIST_BITS global history register, shifted left on each update_valid, inserting update_taken at bit 0.
  - Lookup index = lookup_idx XOR zero-extended history. The read uses the pre-shift history when an update coincides.
  - Reset and flush clear history.
- Not defined: no history register; pred_index = lookup_idx; HIST_BITS is ignored.

Test Plan:
- Reset, then lookup idx 3 -> next cycle pred_valid=1, prediction=0, pred_strong=0, pred_index=3.
- MODE0, CTR_BITS=2: 4x taken updates to idx 5, then lookup idx 5 -> prediction=1, pred_strong=1. 1x not-taken, then lookup -> prediction=1, pred_strong=0.
- MODE1, CTR_BITS=2: one taken update to idx 2 (01->11), lookup -> prediction=1, pred_strong=1. Compare MODE0: same sequence -> prediction=1, pred_strong=0.
- CTR_BITS=3, MODE0: 8 not-taken updates to idx 0 -> counter sticks at 0, no underflow. 8 taken -> 7, no overflow.
- Same cycle, lookup idx 7 and update idx 7 taken from INIT: pred shows 0. Re-lookup shows 1. flush+update same edge -> counter = INIT.
- BPRED_GSHARE_EN, HIST_BITS=4: updates T,T,N,T (history=4'b1101), then lookup idx 4'b0001 -> pred_index=4'b1100. Assert reset mid-stream -> history 0, pred_valid 0 immediately.

Source files
------------

// File: rtl/multi_bit_bpred_table.sv
// Table of saturating branch-direction counters with a registered lookup port.
// Optional global-history (gshare) indexing is enabled by BPRED_GSHARE_EN.
module multi_bit_bpred_table #(
  parameter int CTR_BITS   = 2,
  parameter int INDEX_BITS = 4,
  parameter int MODE       = 0,
  parameter int HIST_BITS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  lookup_valid,
  input  logic [INDEX_BITS-1:0] lookup_idx,
  output logic                  pred_valid,
  output logic                  prediction,
  output logic                  pred_strong,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_idx,
  input  logic                  update_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] INIT =
    {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] WT =
    {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] MAXV = '1;

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   rd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_d;
  logic [INDEX_BITS-1:0] rd_idx;

  logic                  pred_valid_q;
  logic                  prediction_q;
  logic                  pred_strong_q;
  logic [INDEX_BITS-1:0] pred_index_q;

`ifdef BPRED_GSHARE_EN
  logic [HIST_BITS-1:0] hist_q;
  logic [HIST_BITS-1:0] hist_d;

  assign rd_idx = lookup_idx ^ INDEX_BITS'(hist_q);
  assign hist_d = (hist_q << 1) | HIST_BITS'(update_taken);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else if (flush) begin
      hist_q <= '0;
    end else if (update_valid) begin
      hist_q <= hist_d;
    end
  end
`else
  assign rd_idx = lookup_idx;
`endif

  assign rd_ctr = ctr_q[rd_idx];

  // Hysteresis mode jumps a weak counter straight to the opposite strong state
  always_comb begin
    upd_ctr_d = ctr_q[update_idx];
    if (MODE == 1 && update_taken && ctr_q[update_idx] == INIT) begin
      upd_ctr_d = MAXV;
    end else if (MODE == 1 && !update_taken && ctr_q[update_idx] == WT) begin
      upd_ctr_d = '0;
    end else if (update_taken) begin
      if (ctr_q[update_idx] != MAXV)
        upd_ctr_d = ctr_q[update_idx] + 1'b1;
    end else begin
      if (ctr_q[update_idx] != '0)
        upd_ctr_d = ctr_q[update_idx] - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT;
    end else if (update_valid) begin
      ctr_q[update_idx] <= upd_ctr_d;
    end
  end

  // Read-before-write: outputs sample the counter as it stood before this edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid_q  <= 1'b0;
      prediction_q  <= 1'b0;
      pred_strong_q <= 1'b0;
      pred_index_q  <= '0;
    end else begin
      pred_valid_q <= lookup_valid;
      if (lookup_valid) begin
        prediction_q  <= rd_ctr[CTR_BITS-1];
        pred_strong_q <= (rd_ctr == '0) || (rd_ctr == MAXV);
        pred_index_q  <= rd_idx;
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign prediction  = prediction_q;
  assign pred_strong = pred_strong_q;
  assign pred_index  = pred_index_q;

endmodule

// File: tb/tb_multi_bit_bpred_table.sv
// Directed bench: d0 = 2-bit saturating, d1 = 2-bit hysteresis,
// d2 = 3-bit saturating, all driven by the same stimulus.
module tb_multi_bit_bpred_table;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  logic lookup_valid;
  logic [3:0] lookup_idx;
  logic update_valid;
  logic [3:0] update_idx;
  logic update_taken;

  logic [2:0] pv, pr, ps;
  logic [3:0] pi0, pi1, pi2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  multi_bit_bpred_table #(.CTR_BITS(2), .INDEX_BITS(4), .MODE(0), .HIST_BITS(4)) d0 (
    .clock(clock), .reset(reset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .pred_valid(pv[0]), .prediction(pr[0]), .pred_strong(ps[0]), .pred_index(pi0),
    .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
  );

  multi_bit_bpred_table #(.CTR_BITS(2), .INDEX_BITS(4), .MODE(1), .HIST_BITS(4)) d1 (
    .clock(clock), .reset(reset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .pred_valid(pv[1]), .prediction(pr[1]), .pred_strong(ps[1]), .pred_index(pi1),
    .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
  );

  multi_bit_bpred_table #(.CTR_BITS(3), .INDEX_BITS(4), .MODE(0), .HIST_BITS(4)) d2 (
    .clock(clock), .reset(reset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .pred_valid(pv[2]), .prediction(pr[2]), .pred_strong(ps[2]), .pred_index(pi2),
    .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
  );

  typedef struct {
    logic       lv;
    logic [3:0] lidx;
    logic       uv;
    logic [3:0] uidx;
    logic       ut;
    logic       fl;
    logic       e_pv;
    logic       e_pr;
    logic       e_ps;
    logic [3:0] e_idx;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [3:0] li,
                       input logic uv, input logic [3:0] ui,
                       input logic ut, input logic fl);
    lookup_valid = lv;
    lookup_idx   = li;
    update_valid = uv;
    update_idx   = ui;
    update_taken = ut;
    flush        = fl;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    //              lv lidx  uv uidx ut fl  pv pr ps idx
    vecs[0]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[5]  = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5};
    vecs[7]  = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5};
    vecs[8]  = '{1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
    vecs[9]  = '{1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7};
    vecs[10] = '{1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7};
    vecs[11] = '{1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
    vecs[12] = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5};
    vecs[13] = '{1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
    vecs[15] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

    reset = 1'b0;
    idle();
    #1;
    chk("reset_pv", 32'(pv[0]), 32'd0);
    chk("reset_pr", 32'(pr[0]), 32'd0);
    chk("reset_ps", 32'(ps[0]), 32'd0);
    chk("reset_idx", 32'(pi0), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].lv, vecs[i].lidx, vecs[i].uv, vecs[i].uidx, vecs[i].ut, vecs[i].fl);
      tick();
      chk($sformatf("v%0d_pv", i), 32'(pv[0]), 32'(vecs[i].e_pv));
      chk($sformatf("v%0d_pr", i), 32'(pr[0]), 32'(vecs[i].e_pr));
      chk($sformatf("v%0d_ps", i), 32'(ps[0]), 32'(vecs[i].e_ps));
      chk($sformatf("v%0d_idx", i), 32'(pi0), 32'(vecs[i].e_idx));
    end

    // Hysteresis vs saturating from INIT on one taken update
    idle();
    pulse_reset();
    drive(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("m1_pr", 32'(pr[1]), 32'd1);
    chk("m1_ps", 32'(ps[1]), 32'd1);
    chk("m0_pr", 32'(pr[0]), 32'd1);
    chk("m0_ps", 32'(ps[0]), 32'd0);
    chk("c3_pr", 32'(pr[2]), 32'd1);
    chk("c3_ps", 32'(ps[2]), 32'd0);
    chk("m1_idx", 32'(pi1), 32'd2);

    drive(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("m1_11N_pr", 32'(pr[1]), 32'd1);
    chk("m1_11N_ps", 32'(ps[1]), 32'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("m1_10N_pr", 32'(pr[1]), 32'd0);
    chk("m1_10N_ps", 32'(ps[1]), 32'd1);

    // 3-bit counter saturation at both ends
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("c3_lo_pr", 32'(pr[2]), 32'd0);
    chk("c3_lo_ps", 32'(ps[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("c3_hi_pr", 32'(pr[2]), 32'd1);
    chk("c3_hi_ps", 32'(ps[2]), 32'd1);
    chk("c3_hi_pv", 32'(pv[2]), 32'd1);

    // Asynchronous reset in the middle of a cycle
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pv", 32'(pv[2]), 32'd0);
    chk("arst_pr", 32'(pr[2]), 32'd0);
    chk("arst_ps", 32'(ps[2]), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("arst_init_pv", 32'(pv[2]), 32'd1);
    chk("arst_init_pr", 32'(pr[2]), 32'd0);
    chk("arst_init_ps", 32'(ps[2]), 32'd0);

`ifdef BPRED_GSHARE_EN
    idle();
    pulse_reset();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("gs_idx", 32'(pi0), 32'd12);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("gs_rst_pv", 32'(pv[0]), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("gs_rst_idx", 32'(pi0), 32'd1);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
